sample_byte_packer: RTL

- Transmit-side counterpart of the 2-byte sample reader.
- Accepts tagged samples ({6-bit channel, 10-bit data}) over a valid/ready handshake and buffers them in an internal FIFO.
- Serialises each sample MSB-byte-first onto an 8-bit byte stream, which is the same byte format the reader concatenates as {regA,regB}.
- Sits between the acquisition front end and the link/dataset writer, with a per-ring enable mask for dropping unwanted rings.

---
 rtl/sample_byte_packer.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/sample_byte_packer.sv
// sample_byte_packer
//   Buffers tagged samples {channel[5:0], data[9:0]} in a small circular FIFO
//   and serialises each one high byte first onto an 8-bit byte stream.
//   Samples whose ring (channel[5:3]) is masked off by ring_en are consumed
//   and counted, but never stored.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   sample_valid/ready   input handshake; sample_ready is registered (!full)
//   channel, data     sample tag and value
//   ring_en           per-ring enable mask, quasi-static
//   byte_valid/ready  output handshake
//   byte_out          serialised byte; byte_last marks the low byte
//   fifo_count        samples currently buffered (excludes the one being sent)
//   drop_count        samples discarded by ring_en, saturating
//
// Handshake semantics (both sides): a transfer happens on a rising clk edge
// where valid and ready are both high. The source holds its payload stable and
// keeps valid asserted until that edge; ready may change freely.
//
// The output FSM state is the enum `state` (IDLE/HI/LO), readable
// hierarchically as a debug signal.
module sample_byte_packer #(
  parameter int NUM_BITS = 10,
  parameter int DEPTH    = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     sample_valid,
  output logic                     sample_ready,
  input  logic [5:0]               channel,
  input  logic [NUM_BITS-1:0]      data,
  input  logic [7:0]               ring_en,
  output logic                     byte_valid,
  input  logic                     byte_ready,
  output logic [7:0]               byte_out,
  output logic                     byte_last,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [15:0]              drop_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HI   = 2'd1,
    ST_LO   = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [15:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [15:0]      rd_word;
  logic [7:0]       lo_byte;      // low byte of the word currently being sent
  logic             ring_ok, accept, push, pop, fifo_empty;
  logic [CNT_W-1:0] count_nxt;
  logic             byte_valid_nxt, byte_last_nxt;
  logic [7:0]       byte_out_nxt;

  assign ring_ok    = ring_en[channel[5:3]];
  assign accept     = sample_valid && sample_ready;
  assign push       = accept && ring_ok;
  assign fifo_empty = (fifo_count == '0);
  assign rd_word    = mem[rd_ptr];

  // ---------------------------------------------------------------- FIFO
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {channel, data};
  end

  always_comb begin
    count_nxt = fifo_count;
    if (push && !pop)      count_nxt = fifo_count + CNT_W'(1);
    else if (!push && pop) count_nxt = fifo_count - CNT_W'(1);
  end

  // Pop is decided from the registered count, so a word pushed into an empty
  // FIFO only becomes visible to the FSM on the following cycle.
  // sample_ready follows the next count, so a pop while full reopens ready
  // only after the edge that performed it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_count   <= '0;
      sample_ready <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      fifo_count   <= count_nxt;
      sample_ready <= (count_nxt != FULL_CNT);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_count <= '0;
    end else if (accept && !ring_ok && (drop_count != 16'hFFFF)) begin
      drop_count <= drop_count + 16'd1;
    end
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = ST_HI;
        end
      end
      ST_HI: begin
        if (byte_ready) state_nxt = ST_LO;
      end
      ST_LO: begin
        if (byte_ready) begin
          // Chain straight into the next sample to avoid a bubble.
          if (!fifo_empty) begin
            pop       = 1'b1;
            state_nxt = ST_HI;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    byte_valid_nxt = byte_valid;
    byte_out_nxt   = byte_out;
    byte_last_nxt  = byte_last;
    if (pop) begin
      byte_valid_nxt = 1'b1;
      byte_out_nxt   = rd_word[15:8];
      byte_last_nxt  = 1'b0;
    end else if ((state == ST_HI) && byte_ready) begin
      byte_out_nxt   = lo_byte;
      byte_last_nxt  = 1'b1;
    end else if ((state == ST_LO) && byte_ready) begin
      byte_valid_nxt = 1'b0;
      byte_last_nxt  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_valid <= 1'b0;
      byte_out   <= '0;
      byte_last  <= 1'b0;
      lo_byte    <= '0;
    end else begin
      byte_valid <= byte_valid_nxt;
      byte_out   <= byte_out_nxt;
      byte_last  <= byte_last_nxt;
      if (pop) lo_byte <= rd_word[7:0];
    end
  end

endmodule
